// File: rtl/clint_read_arbiter.sv
// clint_read_arbiter
//   Round-robin arbiter sharing one AXI-lite-style read port (CLINT / timer
//   slave) between two masters: m0 (IFU) and m1 (LSU). One transaction is
//   outstanding at a time; the grant is held from address acceptance until
//   the data handshake completes. A slave that never accepts the address is
//   caught by a timeout and the requester receives an error response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m{0,1}_raddr/_rsize        master read address / access size
//   m{0,1}_raddr_valid/_ready  master address handshake (ready is a 1-cycle pulse)
//   m{0,1}_rdata/_rdata_valid  master read data / data valid
//   m{0,1}_rdata_ready         master data ready
//   m{0,1}_rerr                error flag, qualified by rdata_valid
//   s_raddr/_rsize             slave address / size (from latched registers)
//   s_raddr_valid/_ready       slave address handshake
//   s_rdata/_rdata_valid       slave read data / data valid
//   s_rdata_ready              slave data ready
//   busy                       high in any state other than IDLE
//   grant_id                   current/last granted master (0 = m0, 1 = m1)
module clint_read_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] m0_raddr,
  input  logic [2:0]        m0_rsize,
  input  logic              m0_raddr_valid,
  output logic              m0_raddr_ready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rdata_valid,
  input  logic              m0_rdata_ready,
  output logic              m0_rerr,

  input  logic [ADDR_W-1:0] m1_raddr,
  input  logic [2:0]        m1_rsize,
  input  logic              m1_raddr_valid,
  output logic              m1_raddr_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rdata_valid,
  input  logic              m1_rdata_ready,
  output logic              m1_rerr,

  output logic [ADDR_W-1:0] s_raddr,
  output logic [2:0]        s_rsize,
  output logic              s_raddr_valid,
  input  logic              s_raddr_ready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rdata_valid,
  output logic              s_rdata_ready,

  output logic              busy,
  output logic              grant_id
);

  // Counter is at least one bit wide so TIMEOUT = 0 (disabled) still elaborates.
  localparam int unsigned      CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic arb_any;
  logic arb_sel;
  logic gnt_rdata_ready;
  logic timeout_hit;

  // On a tie the master that was not served last wins.
  assign arb_any         = m0_raddr_valid | m1_raddr_valid;
  assign arb_sel         = (m0_raddr_valid & m1_raddr_valid) ? ~rr_last_q : m1_raddr_valid;
  assign gnt_rdata_ready = grant_q ? m1_rdata_ready : m0_rdata_ready;
  assign timeout_hit     = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_sel;
          addr_d  = arb_sel ? m1_raddr : m0_raddr;
          size_d  = arb_sel ? m1_rsize : m0_rsize;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // In the timeout cycle s_raddr_valid is already low, so a late
        // s_raddr_ready must not count as an address handshake.
        if (timeout_hit) begin
          state_d = ERR;
        end else if (s_raddr_ready) begin
          cnt_d   = '0;
          state_d = DATA;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (s_rdata_valid && gnt_rdata_ready) begin
          rr_last_d = grant_q;
          state_d   = IDLE;
        end
      end
      ERR: begin
        if (gnt_rdata_ready) begin
          rr_last_d = grant_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_raddr_ready = 1'b0;
    m0_rdata       = '0;
    m0_rdata_valid = 1'b0;
    m0_rerr        = 1'b0;
    m1_raddr_ready = 1'b0;
    m1_rdata       = '0;
    m1_rdata_valid = 1'b0;
    m1_rerr        = 1'b0;
    s_raddr        = addr_q;
    s_rsize        = size_q;
    s_raddr_valid  = 1'b0;
    s_rdata_ready  = 1'b0;
    busy           = (state_q != IDLE);
    grant_id       = grant_q;
    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so the combinational ready stays low while in reset.
        if (rst_n && arb_any) begin
          if (arb_sel) m1_raddr_ready = 1'b1;
          else         m0_raddr_ready = 1'b1;
        end
      end
      ADDR: begin
        s_raddr_valid = ~timeout_hit;
      end
      DATA: begin
        s_rdata_ready = gnt_rdata_ready;
        if (grant_q) begin
          m1_rdata_valid = s_rdata_valid;
          m1_rdata       = s_rdata;
        end else begin
          m0_rdata_valid = s_rdata_valid;
          m0_rdata       = s_rdata;
        end
      end
      ERR: begin
        if (grant_q) begin
          m1_rdata_valid = 1'b1;
          m1_rerr        = 1'b1;
        end else begin
          m0_rdata_valid = 1'b1;
          m0_rerr        = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_read_arbiter.sv
// tb_clint_read_arbiter
//   Self-checking bench for clint_read_arbiter (TIMEOUT = 4). Expected values
//   come from a transaction-level model: round-robin order from the last
//   served master, per-transaction cycle counts from the slave/master wait
//   times chosen by the bench, and read data from what the bench's slave
//   returned.
module tb_clint_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [63:0] m0_raddr, m1_raddr, s_raddr;
  logic [2:0]  m0_rsize, m1_rsize, s_rsize;
  logic        m0_raddr_valid, m0_raddr_ready, m0_rdata_valid, m0_rdata_ready, m0_rerr;
  logic        m1_raddr_valid, m1_raddr_ready, m1_rdata_valid, m1_rdata_ready, m1_rerr;
  logic [63:0] m0_rdata, m1_rdata, s_rdata;
  logic        s_raddr_valid, s_raddr_ready, s_rdata_valid, s_rdata_ready;
  logic        busy, grant_id;

  int checks = 0;
  int errors = 0;
  logic mdl_last;  // last served master in the reference model

  clint_read_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_raddr(m0_raddr), .m0_rsize(m0_rsize), .m0_raddr_valid(m0_raddr_valid),
    .m0_raddr_ready(m0_raddr_ready), .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
    .m0_rdata_ready(m0_rdata_ready), .m0_rerr(m0_rerr),
    .m1_raddr(m1_raddr), .m1_rsize(m1_rsize), .m1_raddr_valid(m1_raddr_valid),
    .m1_raddr_ready(m1_raddr_ready), .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
    .m1_rdata_ready(m1_rdata_ready), .m1_rerr(m1_rerr),
    .s_raddr(s_raddr), .s_rsize(s_rsize), .s_raddr_valid(s_raddr_valid),
    .s_raddr_ready(s_raddr_ready), .s_rdata(s_rdata), .s_rdata_valid(s_rdata_valid),
    .s_rdata_ready(s_rdata_ready), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  function automatic logic [204:0] all_outs();
    return {m0_raddr_ready, m0_rdata, m0_rdata_valid, m0_rerr,
            m1_raddr_ready, m1_rdata, m1_rdata_valid, m1_rerr,
            s_raddr, s_rsize, s_raddr_valid, s_rdata_ready, busy, grant_id};
  endfunction

  task automatic drive_idle();
    m0_raddr = '0; m0_rsize = '0; m0_raddr_valid = 0; m0_rdata_ready = 0;
    m1_raddr = '0; m1_rsize = '0; m1_raddr_valid = 0; m1_rdata_ready = 0;
    s_raddr_ready = 0; s_rdata = '0; s_rdata_valid = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive_idle();
    m0_raddr_valid = 1; m1_raddr_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outs: got %h required 0", all_outs());
    end
    next_cycle();
    rst_n = 1; drive_idle(); mdl_last = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL idle_outs: got %h required 0", all_outs());
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    m1_raddr = 64'h0200_0000; m1_rsize = 3'd3; m1_raddr_valid = 1;
    @(negedge clk);
    checks++;
    if ({m1_raddr_ready, m0_raddr_ready, busy} !== 3'b100) begin
      errors++; $display("FAIL single_c0: got %b required 100", {m1_raddr_ready, m0_raddr_ready, busy});
    end
    next_cycle();
    m1_raddr_valid = 0; m1_raddr = 64'hdead_beef; s_raddr_ready = 1;
    @(negedge clk);
    checks++;
    if ({s_raddr_valid, s_raddr, s_rsize, busy, grant_id, m1_raddr_ready} !==
        {1'b1, 64'h0200_0000, 3'd3, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_c1: got %b %h %0d %b %b required 1 02000000 3 1 1",
                         s_raddr_valid, s_raddr, s_rsize, busy, grant_id);
    end
    next_cycle();
    s_raddr_ready = 0; s_rdata_valid = 1; s_rdata = 64'h1234; m1_rdata_ready = 1;
    @(negedge clk);
    checks++;
    if ({m1_rdata_valid, m1_rdata, m1_rerr, s_rdata_ready, busy, m0_rdata_valid} !==
        {1'b1, 64'h1234, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_c2: got %b %h %b %b %b required 1 1234 0 1 1",
                         m1_rdata_valid, m1_rdata, m1_rerr, s_rdata_ready, busy);
    end
    next_cycle();
    mdl_last = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++;
    if ({busy, grant_id, m1_rdata_valid} !== 3'b010) begin
      errors++; $display("FAIL single_c3: got %b required 010", {busy, grant_id, m1_rdata_valid});
    end
    next_cycle();
  endtask

  // Both masters hold valid; random slave/master waits; the non-granted
  // master's address is scrambled every cycle to check isolation.
  task automatic test_round_robin_random();
    logic        exp_g, gv, gerr, ov, oerr;
    logic [63:0] exp_addr, data, gd, od;
    logic [2:0]  exp_size;
    int          aw, dw, rw, nd;
    for (int t = 0; t < 24; t++) begin
      exp_g = ~mdl_last;
      aw = $urandom_range(0, 3); dw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      data = {$urandom, $urandom};
      m0_raddr = {$urandom, $urandom}; m1_raddr = {$urandom, $urandom};
      m0_rsize = 3'($urandom); m1_rsize = 3'($urandom);
      m0_raddr_valid = 1; m1_raddr_valid = 1;
      m0_rdata_ready = 0; m1_rdata_ready = 0;
      s_raddr_ready = 0; s_rdata_valid = 0;
      exp_addr = exp_g ? m1_raddr : m0_raddr;
      exp_size = exp_g ? m1_rsize : m0_rsize;
      @(negedge clk);
      checks++;
      if ({m1_raddr_ready, m0_raddr_ready, busy} !== {exp_g, ~exp_g, 1'b0}) begin
        errors++; $display("FAIL rr_grant t=%0d: got m1r=%b m0r=%b busy=%b required grant m%0d",
                           t, m1_raddr_ready, m0_raddr_ready, busy, exp_g);
      end
      next_cycle();
      for (int k = 0; k <= aw; k++) begin
        m0_raddr = {$urandom, $urandom}; m1_raddr = {$urandom, $urandom};
        m0_rsize = 3'($urandom); m1_rsize = 3'($urandom);
        s_raddr_ready = (k == aw);
        @(negedge clk);
        checks++;
        if ({s_raddr_valid, s_raddr, s_rsize, busy, grant_id} !== {1'b1, exp_addr, exp_size, 1'b1, exp_g}) begin
          errors++; $display("FAIL rr_addr t=%0d k=%0d: got %b %h %0d %b %b required 1 %h %0d 1 %b",
                             t, k, s_raddr_valid, s_raddr, s_rsize, busy, grant_id, exp_addr, exp_size, exp_g);
        end
        checks++;
        if ({m0_raddr_ready, m1_raddr_ready, m0_rdata_valid, m1_rdata_valid} !== 4'b0) begin
          errors++; $display("FAIL rr_addr_quiet t=%0d: got %b required 0000", t,
                             {m0_raddr_ready, m1_raddr_ready, m0_rdata_valid, m1_rdata_valid});
        end
        next_cycle();
      end
      s_raddr_ready = 0;
      nd = (dw > rw) ? dw : rw;
      for (int k = 0; k <= nd; k++) begin
        s_rdata_valid = (k >= dw);
        s_rdata = (k >= dw) ? data : {$urandom, $urandom};
        if (exp_g) begin m1_rdata_ready = (k >= rw); m0_rdata_ready = 1'($urandom); end
        else       begin m0_rdata_ready = (k >= rw); m1_rdata_ready = 1'($urandom); end
        @(negedge clk);
        gv = exp_g ? m1_rdata_valid : m0_rdata_valid;
        gd = exp_g ? m1_rdata : m0_rdata;
        gerr = exp_g ? m1_rerr : m0_rerr;
        ov = exp_g ? m0_rdata_valid : m1_rdata_valid;
        od = exp_g ? m0_rdata : m1_rdata;
        oerr = exp_g ? m0_rerr : m1_rerr;
        checks++;
        if ({gv, gerr, s_rdata_ready, busy} !== {(k >= dw), 1'b0, (k >= rw), 1'b1}) begin
          errors++; $display("FAIL rr_data t=%0d k=%0d: got v=%b err=%b sr=%b busy=%b required v=%b err=0 sr=%b busy=1",
                             t, k, gv, gerr, s_rdata_ready, busy, (k >= dw), (k >= rw));
        end
        if (k >= dw) begin
          checks++;
          if (gd !== data) begin
            errors++; $display("FAIL rr_rdata t=%0d: got %h required %h", t, gd, data);
          end
        end
        checks++;
        if ({ov, od, oerr} !== '0) begin
          errors++; $display("FAIL rr_isolation t=%0d: got v=%b d=%h e=%b required 0", t, ov, od, oerr);
        end
        next_cycle();
      end
      mdl_last = exp_g;
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    int n;
    m0_raddr = 64'h0200_0010; m0_rsize = 3'd2; m0_raddr_valid = 1;
    @(negedge clk);
    checks++;
    if ({m0_raddr_ready, m1_raddr_ready} !== 2'b10) begin
      errors++; $display("FAIL to_grant: got %b required 10", {m0_raddr_ready, m1_raddr_ready});
    end
    next_cycle();
    m0_raddr_valid = 0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!s_raddr_valid) break;
      n++;
      next_cycle();
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL to_valid_cycles: got %0d required 4", n);
    end
    checks++;
    if ({busy, m0_rdata_valid, m0_rerr} !== 3'b100) begin
      errors++; $display("FAIL to_drop_cycle: got %b required 100", {busy, m0_rdata_valid, m0_rerr});
    end
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      m0_rdata_ready = (c == 3);
      @(negedge clk);
      checks++;
      if ({m0_rdata_valid, m0_rerr, m0_rdata, s_rdata_ready, s_raddr_valid, busy} !==
          {1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL to_err c=%0d: got v=%b e=%b d=%h sr=%b sv=%b busy=%b required 1 1 0 0 0 1",
                           c, m0_rdata_valid, m0_rerr, m0_rdata, s_rdata_ready, s_raddr_valid, busy);
      end
      checks++;
      if ({m1_rdata_valid, m1_rerr, m1_rdata} !== '0) begin
        errors++; $display("FAIL to_isolation: got %b %b %h required 0", m1_rdata_valid, m1_rerr, m1_rdata);
      end
      next_cycle();
    end
    mdl_last = 1'b0;
    drive_idle();
    @(negedge clk);
    checks++;
    if ({busy, m0_rerr, m0_rdata_valid} !== 3'b000) begin
      errors++; $display("FAIL to_done: got %b required 000", {busy, m0_rerr, m0_rdata_valid});
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    m1_raddr = 64'h0200_bff8; m1_rsize = 3'd3; m1_raddr_valid = 1;
    next_cycle();
    m1_raddr_valid = 0; s_raddr_ready = 1;
    next_cycle();
    s_raddr_ready = 0; s_rdata_valid = 1; s_rdata = 64'hcafe_f00d_0000_0042;
    for (int c = 0; c < 6; c++) begin
      m1_rdata_ready = (c == 5);
      @(negedge clk);
      checks++;
      if ({s_rdata_ready, busy, m1_rdata_valid, m1_rerr, m1_rdata} !==
          {(c == 5), 1'b1, 1'b1, 1'b0, 64'hcafe_f00d_0000_0042}) begin
        errors++; $display("FAIL bp c=%0d: got sr=%b busy=%b v=%b e=%b d=%h required sr=%b 1 1 0 cafef00d00000042",
                           c, s_rdata_ready, busy, m1_rdata_valid, m1_rerr, m1_rdata, (c == 5));
      end
      next_cycle();
    end
    mdl_last = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++;
    if ({busy, m1_rdata_valid} !== 2'b00) begin
      errors++; $display("FAIL bp_done: got %b required 00", {busy, m1_rdata_valid});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_data();
    m0_raddr = 64'h0200_0000; m0_rsize = 3'd3; m0_raddr_valid = 1;
    next_cycle();
    m0_raddr_valid = 0; s_raddr_ready = 1;
    next_cycle();
    s_raddr_ready = 0; s_rdata_valid = 1; s_rdata = 64'h5555;
    @(negedge clk);
    checks++;
    if ({busy, m0_rdata_valid} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: got %b required 11", {busy, m0_rdata_valid});
    end
    m0_raddr_valid = 1; m1_raddr_valid = 1;
    #2 rst_n = 0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL rst_async: got %h required 0", all_outs());
    end
    next_cycle();
    rst_n = 1; mdl_last = 1'b1;
    m0_raddr = 64'h0200_4000; m1_raddr = 64'h0200_8000;
    @(negedge clk);
    checks++;
    if ({m0_raddr_ready, m1_raddr_ready, busy} !== 3'b100) begin
      errors++; $display("FAIL rst_regrant: got %b required 100", {m0_raddr_ready, m1_raddr_ready, busy});
    end
    next_cycle();
    m0_raddr_valid = 0; m1_raddr_valid = 0; s_rdata_valid = 0; s_raddr_ready = 1;
    @(negedge clk);
    checks++;
    if ({grant_id, s_raddr_valid, s_raddr} !== {1'b0, 1'b1, 64'h0200_4000}) begin
      errors++; $display("FAIL rst_regrant_addr: got %b %b %h required 0 1 02004000",
                         grant_id, s_raddr_valid, s_raddr);
    end
    next_cycle();
    s_raddr_ready = 0; s_rdata_valid = 1; m0_rdata_ready = 1;
    next_cycle();
    mdl_last = 1'b0;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst_n = 0;
    mdl_last = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin_random();
    test_timeout();
    test_backpressure();
    test_reset_mid_data();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
